// File: rtl/ofdm_tx_pkg.sv
// Shared constants, state encoding and parity helper for the OFDM transmit chain.
// The convolutional code is the K=7, rate 1/2 code with generators 133/171 octal.
package ofdm_tx_pkg;

   localparam int unsigned K        = 7;
   localparam int unsigned TAIL_LEN = 6;

   // Generator MSB taps the current bit; lower bits tap progressively older bits.
   localparam logic [K-1:0] G0 = 7'o133;
   localparam logic [K-1:0] G1 = 7'o171;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      OUT_A  = 3'd1,
      OUT_B  = 3'd2,
      TAIL_A = 3'd3,
      TAIL_B = 3'd4
   } conv_state_e;

   // hist[K-2] is the most recent previous bit, hist[0] the oldest.
   function automatic logic conv_parity(input logic         d0,
                                        input logic [K-2:0] hist,
                                        input logic [K-1:0] g);
      return ^({d0, hist} & g);
   endfunction

endpackage

// File: rtl/conv_encoder.sv
// K=7 rate-1/2 convolutional encoder with valid/ready handshakes on both sides.
// Each accepted bit yields A then B; an optional 6-bit zero tail closes every frame.
module conv_encoder
   import ofdm_tx_pkg::*;
#(
   parameter bit TAIL_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       conv_din,
   input  logic       conv_din_vld,
   output logic       conv_dout_rdy,
   input  logic       conv_din_last,
   input  logic [7:0] conv_din_symb_cnt,
   output logic       conv_dout,
   output logic       conv_dout_vld,
   input  logic       conv_din_rdy,
   output logic       conv_dout_last,
   output logic [7:0] conv_dout_symb_cnt
);

   localparam logic [2:0] TAIL_LAST = 3'(TAIL_LEN - 1);

   conv_state_e  state_q, state_d;
   logic [K-2:0] hist_q, hist_d;
   logic         a_q, a_d;
   logic         b_q, b_d;
   logic         last_q, last_d;
   logic [7:0]   symb_q, symb_d;
   logic [2:0]   tail_q, tail_d;

   logic accept;
   logic xfer;
   logic d0;
   logic enc_a;
   logic enc_b;

   // Gated by rst_n so upstream never sees ready while the encoder is held in reset.
   assign conv_dout_rdy = rst_n && ((state_q == IDLE) ||
                                    (state_q == OUT_B && conv_din_rdy && !last_q));
   assign accept        = conv_din_vld && conv_dout_rdy;
   assign xfer          = conv_dout_vld && conv_din_rdy;

   // Tail steps feed zeros; ready is low there, so accept cannot be set.
   assign d0    = accept ? conv_din : 1'b0;
   assign enc_a = conv_parity(d0, hist_q, G0);
   assign enc_b = conv_parity(d0, hist_q, G1);

   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      a_d     = a_q;
      b_d     = b_q;
      last_d  = last_q;
      symb_d  = symb_q;
      tail_d  = tail_q;
      if (accept) begin
         a_d     = enc_a;
         b_d     = enc_b;
         last_d  = conv_din_last;
         symb_d  = conv_din_symb_cnt;
         hist_d  = {conv_din, hist_q[K-2:1]};
         state_d = OUT_A;
      end else begin
         unique case (state_q)
            IDLE: ;
            OUT_A: if (xfer) state_d = OUT_B;
            OUT_B: begin
               if (xfer) begin
                  if (last_q && TAIL_EN) begin
                     a_d     = enc_a;
                     b_d     = enc_b;
                     hist_d  = {1'b0, hist_q[K-2:1]};
                     tail_d  = '0;
                     state_d = TAIL_A;
                  end else begin
                     state_d = IDLE;
                     if (last_q) begin
                        hist_d = '0;
                        last_d = 1'b0;
                     end
                  end
               end
            end
            TAIL_A: if (xfer) state_d = TAIL_B;
            TAIL_B: begin
               if (xfer) begin
                  if (tail_q == TAIL_LAST) begin
                     hist_d  = '0;
                     tail_d  = '0;
                     last_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     a_d     = enc_a;
                     b_d     = enc_b;
                     hist_d  = {1'b0, hist_q[K-2:1]};
                     tail_d  = tail_q + 3'd1;
                     state_d = TAIL_A;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hist_q  <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         last_q  <= 1'b0;
         symb_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         a_q     <= a_d;
         b_q     <= b_d;
         last_q  <= last_d;
         symb_q  <= symb_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      conv_dout = 1'b0;
      if (state_q == OUT_A || state_q == TAIL_A) conv_dout = a_q;
      if (state_q == OUT_B || state_q == TAIL_B) conv_dout = b_q;
   end

   assign conv_dout_vld      = (state_q != IDLE);
   assign conv_dout_last     = (state_q == TAIL_B && tail_q == TAIL_LAST) ||
                               (state_q == OUT_B && last_q && !TAIL_EN);
   assign conv_dout_symb_cnt = symb_q;

endmodule
